// File: rtl/sram_port0_arbiter.sv
// Round-robin arbiter/sequencer for SRAM port0 with read-tag tracking.
// Optional SRAM_ARB_INIT_CLEAR_EN: zero-fill the whole memory before accepting traffic.
module sram_port0_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_ADDRESSES = 512,
  parameter int READ_LATENCY  = 2,
  localparam int AW  = $clog2(NUM_ADDRESSES),
  localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int MW  = DATA_WIDTH / 8
) (
  input  logic                       clk0,
  input  logic                       rst0,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*MW-1:0]      req_wmask,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                       rsp_valid,
  output logic [IDW-1:0]             rsp_id,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       init_done,
  output logic                       csb0,
  output logic                       web0,
  output logic [MW-1:0]              wmask0,
  output logic [AW-1:0]              port0_address,
  output logic [DATA_WIDTH-1:0]      port0_datain,
  input  logic [DATA_WIDTH-1:0]      port0_dataout
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic           xfer;

  logic           tag_vld_p [0:READ_LATENCY];
  logic [IDW-1:0] tag_id_p  [0:READ_LATENCY];

`ifdef SRAM_ARB_INIT_CLEAR_EN
  logic [AW-1:0]  init_addr;
`endif

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDW-1:0];
  endfunction

  // Stage 0: combinational round-robin search starting at the pointer
  always_comb begin
    win       = '0;
    found     = 1'b0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rr_idx(ptr, k)]) begin
        found = 1'b1;
        win   = rr_idx(ptr, k);
      end
    end
    if (init_done && found) req_ready[win] = 1'b1;
  end

  assign xfer      = init_done && found;
  assign rsp_rdata = port0_dataout;

  // Stage 1: registered SRAM command; read tags then ride a fixed-depth pipe
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state         <= ST_INIT;
      init_done     <= 1'b0;
      ptr           <= '0;
      csb0          <= 1'b1;
      web0          <= 1'b1;
      wmask0        <= '0;
      port0_address <= '0;
      port0_datain  <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      for (int k = 0; k <= READ_LATENCY; k++) begin
        tag_vld_p[k] <= 1'b0;
        tag_id_p[k]  <= '0;
      end
`ifdef SRAM_ARB_INIT_CLEAR_EN
      init_addr     <= '0;
`endif
    end else begin
      init_done <= (state == ST_RUN);
      csb0      <= 1'b1;
      web0      <= 1'b1;
`ifdef SRAM_ARB_INIT_CLEAR_EN
      if (state == ST_INIT) begin
        csb0          <= 1'b0;
        web0          <= 1'b0;
        wmask0        <= '1;
        port0_address <= init_addr;
        port0_datain  <= '0;
        if (init_addr == AW'(NUM_ADDRESSES - 1)) state <= ST_RUN;
        else init_addr <= init_addr + 1'b1;
      end
`else
      if (state == ST_INIT) state <= ST_RUN;
`endif
      if (xfer) begin
        csb0          <= 1'b0;
        web0          <= ~req_we[win];
        wmask0        <= req_wmask[win*MW +: MW];
        port0_address <= req_addr[win*AW +: AW];
        port0_datain  <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
        ptr           <= rr_idx(win, 1);
      end
      tag_vld_p[0] <= xfer && !req_we[win];
      tag_id_p[0]  <= win;
      for (int k = 1; k <= READ_LATENCY; k++) begin
        tag_vld_p[k] <= tag_vld_p[k-1];
        tag_id_p[k]  <= tag_id_p[k-1];
      end
      // Stage 2: response leaves the pipe as the SRAM data becomes valid
      rsp_valid <= tag_vld_p[READ_LATENCY];
      rsp_id    <= tag_id_p[READ_LATENCY];
    end
  end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Testbench for sram_port0_arbiter: SRAM model, behavioural reference model and directed checks.
module tb_sram_port0_arbiter;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int NA = 512;
  localparam int L  = 2;
  localparam int AW = 9;
  localparam int MW = 4;
`ifdef SRAM_ARB_INIT_CLEAR_EN
  localparam int DONE_AT = NA + 1;
`else
  localparam int DONE_AT = 2;
`endif

  logic clk0 = 1'b0;
  logic rst0 = 1'b1;
  logic [N-1:0]    req_valid = '0, req_ready, req_we = '0;
  logic [N*MW-1:0] req_wmask = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic            rsp_valid, init_done, csb0, web0;
  logic [0:0]      rsp_id;
  logic [DW-1:0]   rsp_rdata, port0_datain, port0_dataout;
  logic [MW-1:0]   wmask0;
  logic [AW-1:0]   port0_address;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  sram_port0_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .NUM_ADDRESSES(NA), .READ_LATENCY(L)) dut (
    .clk0(clk0), .rst0(rst0), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .init_done(init_done), .csb0(csb0), .web0(web0),
    .wmask0(wmask0), .port0_address(port0_address), .port0_datain(port0_datain),
    .port0_dataout(port0_dataout));

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // SRAM port0 behaviour: samples commands at the edge, data valid L cycles later
  logic [DW-1:0] mem [0:NA-1];
  logic [DW-1:0] rd_p [0:L];
  always @(posedge clk0) begin
    if (csb0 === 1'b0 && web0 === 1'b0)
      for (int b = 0; b < MW; b++)
        if (wmask0[b]) mem[port0_address][8*b +: 8] <= port0_datain[8*b +: 8];
    rd_p[0] <= (csb0 === 1'b0 && web0 === 1'b1) ? mem[port0_address] : '0;
    for (int k = 1; k <= L; k++) rd_p[k] <= rd_p[k-1];
  end
  assign port0_dataout = rd_p[L];

  // Reference model: expectations for the cycle being sampled, then effects of the coming edge
  typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
  rsp_t          rq [$];
  logic [DW-1:0] shadow [0:NA-1];
  int   mptr = 0, run_cnt = 0, ncyc = 0;
  bit   e_init = 0, e_csb = 1, e_web = 1;
  logic [MW-1:0] e_mask = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;

  always @(negedge clk0) begin
    logic [N-1:0] er;
    int w, a;
    bit ev;
    er = '0;
    w  = -1;
    if (e_init)
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
    if (w >= 0) er[w] = 1'b1;
    chk("m_req_ready", req_ready, er);
    chk("m_init_done", init_done, e_init);
    chk("m_csb0", csb0, e_csb);
    chk("m_web0", web0, e_web);
    chk("m_wmask0", wmask0, e_mask);
    chk("m_address", port0_address, e_addr);
    chk("m_datain", port0_datain, e_data);
    ev = (rq.size() > 0) && (rq[0].due == ncyc);
    chk("m_rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("m_rsp_id", rsp_id, rq[0].id);
      chk("m_rsp_rdata", rsp_rdata, rq[0].data);
      void'(rq.pop_front());
    end
    if (rst0) begin
      rq.delete();
      mptr = 0; run_cnt = 0; e_init = 0; e_csb = 1; e_web = 1;
      e_mask = '0; e_addr = '0; e_data = '0;
    end else begin
      run_cnt++;
      e_csb = 1; e_web = 1;
`ifdef SRAM_ARB_INIT_CLEAR_EN
      if (run_cnt <= NA) begin
        e_csb = 0; e_web = 0; e_mask = '1; e_addr = AW'(run_cnt - 1); e_data = '0;
        shadow[run_cnt - 1] = '0;
      end
`endif
      if (w >= 0) begin
        a      = int'(req_addr[w*AW +: AW]);
        e_csb  = 0;
        e_web  = ~req_we[w];
        e_mask = req_wmask[w*MW +: MW];
        e_addr = req_addr[w*AW +: AW];
        e_data = req_wdata[w*DW +: DW];
        if (req_we[w]) begin
          for (int b = 0; b < MW; b++)
            if (e_mask[b]) shadow[a][8*b +: 8] = e_data[8*b +: 8];
        end else begin
          rq.push_back('{due: ncyc + L + 2, id: w, data: shadow[a]});
        end
        mptr = (w + 1) % N;
      end
      e_init = (run_cnt >= DONE_AT);
    end
    ncyc++;
  end

  // All stimulus tasks start and end one time unit after a rising edge
  task automatic issue(input int id, input bit we, input int a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m, output int acc);
    bit got;
    got = 0;
    acc = 0;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_we[id] = we;
    req_addr[id*AW +: AW] = a[AW-1:0];
    req_wdata[id*DW +: DW] = d;
    req_wmask[id*MW +: MW] = m;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk0);
      if (req_ready[id]) begin got = 1; acc = cyc + 1; end
    end
    chk("accept", got, 1);
    @(posedge clk0); #1;
    req_valid = '0;
  endtask

  task automatic wait_rsp(input string name, input int acc, input int id, input logic [DW-1:0] d);
    bit got;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk0);
      if (rsp_valid) got = 1;
    end
    chk({name, "_seen"}, got, 1);
    chk({name, "_latency"}, cyc - acc, 3);
    chk({name, "_id"}, rsp_id, id);
    chk({name, "_rdata"}, rsp_rdata, d);
    @(posedge clk0); #1;
  endtask

  task automatic wait_init(input int bound);
    bit got;
    got = 0;
    for (int t = 0; t < bound && !got; t++) begin
      @(negedge clk0);
      if (init_done) got = 1;
    end
    chk("init_done_seen", got, 1);
    @(posedge clk0); #1;
  endtask

  task automatic pulse_reset();
    rst0 = 1'b1;
    @(posedge clk0); #1;
    rst0 = 1'b0;
  endtask

  initial begin
    int acc, rel;
    bit got;
    for (int i = 0; i < NA; i++) begin
      mem[i]    = 32'hA5A5_0000 ^ i;
      shadow[i] = 32'hA5A5_0000 ^ i;
    end
    for (int k = 0; k <= L; k++) rd_p[k] = '0;

    repeat (3) @(posedge clk0);
    @(negedge clk0);
    chk("reset_csb0", csb0, 1);
    chk("reset_web0", web0, 1);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_init_done", init_done, 0);
    chk("reset_rsp_id", rsp_id, 0);
    @(posedge clk0); #1;
    rst0 = 1'b0;
    @(negedge clk0);
    rel = cyc;
    got = init_done;
    for (int t = 0; t < 600 && !got; t++) begin
      @(negedge clk0);
      got = init_done;
    end
    chk("init_done_rise", got, 1);
    chk("init_latency", cyc - rel, DONE_AT);
    @(posedge clk0); #1;

`ifdef SRAM_ARB_INIT_CLEAR_EN
    issue(0, 0, NA - 1, '0, '0, acc);
    wait_rsp("init_clear", acc, 0, 32'h0);
`endif

    issue(0, 1, 5, 32'hDEADBEEF, 4'hF, acc);
    issue(0, 0, 5, '0, '0, acc);
    wait_rsp("wr_rd", acc, 0, 32'hDEADBEEF);

    issue(1, 1, 7, 32'hFFFFFFFF, 4'hF, acc);
    issue(1, 1, 7, 32'h00000000, 4'h3, acc);
    issue(1, 0, 7, '0, '0, acc);
    wait_rsp("bytemask", acc, 1, 32'hFFFF0000);

    pulse_reset();
    wait_init(20);
    req_we = '0;
    req_addr = {9'd2, 9'd1};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk0);
      chk("rr_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk0); #1;
    end
    req_valid = '0;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk0);
      if (rsp_valid) got = 1;
    end
    chk("contention_rsp_seen", got, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk0);
      chk("contention_rsp_valid", rsp_valid, 1);
      chk("contention_rsp_id", rsp_id, k % 2);
    end
    @(posedge clk0); #1;

    issue(0, 0, 5, '0, '0, acc);
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk0);
      chk("reset_drop_rsp", rsp_valid, 0);
    end
    @(posedge clk0); #1;
    wait_init(20);

    for (int c = 0; c < 1500; c++) begin
      req_valid = N'($urandom_range(0, 3));
      req_we    = N'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        req_addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
        req_wdata[i*DW +: DW] = $urandom;
        req_wmask[i*MW +: MW] = MW'($urandom_range(0, 15));
      end
      rst0 = ($urandom_range(0, 199) == 0);
      @(posedge clk0); #1;
    end
    req_valid = '0;
    rst0 = 1'b0;
    repeat (10) @(posedge clk0);
    @(negedge clk0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
